// File: rtl/renorm_emitter.sv
// renorm_emitter: arithmetic-coder renormalisation with pending (E3) bit
// tracking, serial code-bit emission and end-of-stream flush.
module renorm_emitter #(
    parameter int PEND_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_lower,
    input  logic [15:0] in_upper,
    input  logic        in_last,
    output logic        bit_valid,
    input  logic        bit_ready,
    output logic        bit_data,
    output logic        bit_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_lower,
    output logic [15:0] out_upper,
    output logic [31:0] bit_count,
    output logic        pend_ovf
);
    typedef enum logic [2:0] {IDLE, CHECK, EMIT, FLUSH, OUT} state_t;
    state_t state, state_nx;
    logic [15:0] l, u;
    logic [PEND_W-1:0] pending;
    logic [31:0] count;
    logic f, b, first, flush, ovf;
    logic same, e3, pend_max, done;

    assign same = u[15] == l[15];
    assign e3 = l[14] & ~u[14];
    assign pend_max = &pending;
    // true when a handshake on the current bit ends the emission run
    assign done = first ? (pending == '0) : (pending == PEND_W'(1));
    assign out_lower = l;
    assign out_upper = u;
    assign bit_count = count;
    assign pend_ovf = ovf;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        bit_valid = 1'b0;
        bit_data = 1'b0;
        bit_last = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = CHECK;
            end
            CHECK: state_nx = same ? EMIT : e3 ? CHECK : f ? FLUSH : OUT;
            EMIT: begin
                bit_valid = 1'b1;
                bit_data = first ? b : ~b;
                bit_last = flush & done;
                if (bit_ready && done) state_nx = flush ? IDLE : CHECK;
            end
            FLUSH: state_nx = EMIT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l <= '0;
            u <= '0;
            pending <= '0;
            count <= '0;
            f <= 1'b0;
            b <= 1'b0;
            first <= 1'b0;
            flush <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (bit_valid && bit_ready) count <= count + 32'd1;
            case (state)
                IDLE: if (in_valid) begin
                    l <= in_lower;
                    u <= in_upper;
                    f <= in_last;
                end
                CHECK: if (same) begin
                    b <= u[15];
                    first <= 1'b1;
                end else if (e3) begin
                    if (pend_max) ovf <= 1'b1;
                    else pending <= pending + 1'b1;
                    l <= {1'b0, l[13:0], 1'b0};
                    u <= {1'b1, u[13:0], 1'b1};
                end
                EMIT: if (bit_ready) begin
                    if (first) first <= 1'b0;
                    else pending <= pending - 1'b1;
                    if (done && flush) begin
                        pending <= '0;
                        f <= 1'b0;
                        flush <= 1'b0;
                    end else if (done) begin
                        l <= {l[14:0], 1'b0};
                        u <= {u[14:0], 1'b1};
                    end
                end
                FLUSH: begin
                    if (pend_max) ovf <= 1'b1;
                    else pending <= pending + 1'b1;
                    b <= l[14];
                    first <= 1'b1;
                    flush <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
